// File: rtl/pe_layer_sequencer.sv
// Per-PE layer scheduler: clear -> broadcast -> compute -> global barrier, repeated for layer_no layers.
// Optional watchdog enabled by defining PE_LAYER_TIMEOUT_EN.
module pe_layer_sequencer #(
    parameter int PE_IDX      = 0,
    parameter int LAYER_W     = 4,
    parameter int ACT_W       = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pe_start_calc,
    input  logic [LAYER_W-1:0] layer_no,
    input  logic [ACT_W-1:0]   exp_act_no,
    input  logic               bcast_done,
    input  logic               act_consumed,
    input  logic               queue_empty,
    input  logic               sync_ack,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               out_act_clear,
    output logic               bcast_start,
    output logic               comp_en_gate,
    output logic               sync_req,
    output logic               layer_done,
    output logic               calc_done,
    output logic               busy,
    output logic               timeout_err
);

    if (LAYER_W < 1 || ACT_W < 1 || TIMEOUT_CYC < 2 || PE_IDX < 0) begin : g_param_check
        $error("pe_layer_sequencer: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_BCAST,
        S_COMPUTE,
        S_SYNC,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [LAYER_W-1:0] layer_idx_reg, layer_idx_next;
    logic [LAYER_W-1:0] layer_no_reg, layer_no_next;
    logic [ACT_W-1:0]   exp_reg, exp_next;
    logic [ACT_W-1:0]   recv_cnt_reg, recv_cnt_next;
    logic               bcast_seen_reg, bcast_seen_next;
    logic               compute_exit;
    logic               last_layer;

`ifdef PE_LAYER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic            wd_expired;
    logic            timeout_fire;
    logic            timeout_err_reg;
`endif

    // Exit decision uses registered progress, so the earliest exit is the cycle after the last event.
    assign compute_exit = bcast_seen_reg && queue_empty &&
                          ((exp_reg == '0) || (recv_cnt_reg == exp_reg));
    assign last_layer   = (layer_idx_reg == (layer_no_reg - LAYER_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            layer_idx_reg  <= '0;
            layer_no_reg   <= '0;
            exp_reg        <= '0;
            recv_cnt_reg   <= '0;
            bcast_seen_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            layer_idx_reg  <= layer_idx_next;
            layer_no_reg   <= layer_no_next;
            exp_reg        <= exp_next;
            recv_cnt_reg   <= recv_cnt_next;
            bcast_seen_reg <= bcast_seen_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        layer_idx_next  = layer_idx_reg;
        layer_no_next   = layer_no_reg;
        exp_next        = exp_reg;
        recv_cnt_next   = recv_cnt_reg;
        bcast_seen_next = bcast_seen_reg;
        out_act_clear   = 1'b0;
        bcast_start     = 1'b0;
        comp_en_gate    = 1'b0;
        sync_req        = 1'b0;
        layer_done      = 1'b0;
        calc_done       = 1'b0;
`ifdef PE_LAYER_TIMEOUT_EN
        timeout_fire    = 1'b0;
`endif

        // Progress events are recorded from BCAST onward so an early bcast_done is not lost.
        if (state_reg == S_BCAST || state_reg == S_COMPUTE) begin
            if (act_consumed && (recv_cnt_reg != {ACT_W{1'b1}})) begin
                recv_cnt_next = recv_cnt_reg + 1'b1;
            end
            if (bcast_done) begin
                bcast_seen_next = 1'b1;
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (pe_start_calc) begin
                    layer_no_next = layer_no;
                    state_next    = (layer_no == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                out_act_clear   = 1'b1;
                exp_next        = exp_act_no;
                recv_cnt_next   = '0;
                bcast_seen_next = 1'b0;
                state_next      = S_BCAST;
            end
            S_BCAST: begin
                bcast_start  = 1'b1;
                comp_en_gate = 1'b1;
                state_next   = S_COMPUTE;
            end
            S_COMPUTE: begin
                comp_en_gate = 1'b1;
                if (compute_exit) begin
                    state_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (sync_ack) begin
                    layer_done = 1'b1;
                    if (last_layer) begin
                        state_next = S_DONE;
                    end else begin
                        layer_idx_next = layer_idx_reg + 1'b1;
                        state_next     = S_CLEAR;
                    end
                end else begin
                    sync_req = 1'b1;
                end
            end
            S_DONE: begin
                calc_done      = 1'b1;
                layer_idx_next = '0;
                state_next     = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

`ifdef PE_LAYER_TIMEOUT_EN
        // A stalled wait is abandoned without reporting completion.
        if (wd_expired && (state_next == state_reg)) begin
            state_next     = S_IDLE;
            layer_idx_next = '0;
            timeout_fire   = 1'b1;
        end
`endif
    end

    assign layer_idx = layer_idx_reg;
    assign busy      = (state_reg != S_IDLE);

`ifdef PE_LAYER_TIMEOUT_EN
    assign wd_expired = ((state_reg == S_COMPUTE) || (state_reg == S_SYNC)) &&
                        (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1)) &&
                        !act_consumed && !bcast_done;

    always_comb begin
        wd_cnt_next = wd_cnt_reg + 1'b1;
        if ((state_next != state_reg) || act_consumed || bcast_done) begin
            wd_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
            if (timeout_fire) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
